pc_control: RTL and testbench

//   Control-flow resolution and exception sequencer for the single-cycle WISC-SP16 datapath.

---
 rtl/pc_control.sv | 103 ++++++++++
 tb/tb_pc_control.sv | 114 +++++++++++
 2 files changed

// File: rtl/pc_control.sv
// pc_control: next-PC resolution, EPC register and RUN/HANDLER/HALTED sequencing
module pc_control #(
   parameter logic [15:0] EXC_VECTOR = 16'h0002,
   parameter logic [15:0] EPC_RESET  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Instr,
   input  logic [15:0] IncPC,
   input  logic [15:0] RsData,
   output logic [15:0] NextPC,
   output logic        Halt,
   output logic        Exception,
   output logic [15:0] epc,
   output logic        LinkWr,
   output logic        Err
);
   typedef enum logic [1:0] {RUN, HANDLER, HALTED} state_t;
   state_t      state_q, state_d;
   logic [15:0] epc_q, epc_d;
   logic        err_q, err_d;
   logic [4:0]  opc;
   logic [15:0] sext11, sext8, stall_pc;
   assign opc      = Instr[15:11];
   assign sext11   = {{5{Instr[10]}}, Instr[10:0]};
   assign sext8    = {{8{Instr[7]}}, Instr[7:0]};
   assign stall_pc = IncPC - 16'd2;
   assign epc      = epc_q;
   assign Err      = err_q;
   // decode the current instruction into next PC, strobes and next state
   always_comb begin
      state_d   = state_q;
      epc_d     = epc_q;
      err_d     = err_q;
      NextPC    = IncPC;
      Halt      = 1'b0;
      Exception = 1'b0;
      LinkWr    = 1'b0;
      if (state_q == HALTED) begin
         Halt   = 1'b1;
         NextPC = stall_pc;
      end else begin
         case (opc)
            5'b00000: begin
               Halt    = 1'b1;
               NextPC  = stall_pc;
               state_d = HALTED;
            end
            5'b00100: NextPC = IncPC + sext11;
            5'b00110: begin
               NextPC = IncPC + sext11;
               LinkWr = 1'b1;
            end
            5'b00101: NextPC = RsData + sext8;
            5'b00111: begin
               NextPC = RsData + sext8;
               LinkWr = 1'b1;
            end
            5'b01100: NextPC = (RsData == 16'd0) ? IncPC + sext8 : IncPC;
            5'b01101: NextPC = (RsData != 16'd0) ? IncPC + sext8 : IncPC;
            5'b01110: NextPC = RsData[15] ? IncPC + sext8 : IncPC;
            5'b01111: NextPC = !RsData[15] ? IncPC + sext8 : IncPC;
            5'b00010: begin
               if (state_q == RUN) begin
                  Exception = 1'b1;
                  NextPC    = EXC_VECTOR;
                  epc_d     = IncPC;
                  state_d   = HANDLER;
               end else begin
                  err_d   = 1'b1;
                  Halt    = 1'b1;
                  NextPC  = stall_pc;
                  state_d = HALTED;
               end
            end
            5'b00011: begin
               if (state_q == HANDLER) begin
                  NextPC  = epc_q;
                  state_d = RUN;
               end else begin
                  err_d   = 1'b1;
                  Halt    = 1'b1;
                  NextPC  = stall_pc;
                  state_d = HALTED;
               end
            end
            default: NextPC = IncPC;
         endcase
      end
   end
   // state, EPC and sticky error registers; reset wins over any same-cycle event
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         epc_q   <= EPC_RESET;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: scoreboard bench for pc_control
module tb_pc_control;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Instr, IncPC, RsData;
   logic [15:0] NextPC, epc;
   logic        Halt, Exception, LinkWr, Err;
   int          checks = 0;
   int          errors = 0;
   typedef struct {
      string       tag;
      logic [35:0] v;
   } exp_t;
   exp_t sb[$];

   pc_control dut (
      .clk(clk), .rst(rst), .Instr(Instr), .IncPC(IncPC), .RsData(RsData),
      .NextPC(NextPC), .Halt(Halt), .Exception(Exception), .epc(epc),
      .LinkWr(LinkWr), .Err(Err)
   );

   always #5 clk = ~clk;

   // one comparison: count it and report a mismatch
   task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {npc,h,e,l,err,epc}=%h expected %h", tag, got, exp);
      end
   endtask

   // drive one instruction cycle and queue what the outputs must be mid-cycle
   task automatic step(input string tag, input logic [15:0] i, input logic [15:0] inc,
                       input logic [15:0] rs, input logic [15:0] npc, input logic h,
                       input logic e, input logic l, input logic er, input logic [15:0] ep);
      exp_t x;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      Instr  = i;
      IncPC  = inc;
      RsData = rs;
      x.tag  = tag;
      x.v    = {npc, h, e, l, er, ep};
      sb.push_back(x);
   endtask

   // hold reset for one cycle while presenting an SIIC to prove reset priority
   task automatic do_rst();
      @(posedge clk);
      #1;
      rst   = 1'b1;
      Instr = 16'h1000;
      IncPC = 16'h0030;
   endtask

   // compare combinational outputs and registered state against the queue head
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk(x.tag, {NextPC, Halt, Exception, LinkWr, Err, epc}, x.v);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] r, q;
      rst = 1'b1; Instr = 16'h0000; IncPC = 16'h0000; RsData = 16'h0000;
      repeat (2) @(posedge clk);
      step("nop",      16'h0800, 16'h0012, 16'h0000, 16'h0012, 0, 0, 0, 0, 16'h0000);
      step("beqz_t",   16'h60FC, 16'h0040, 16'h0000, 16'h003C, 0, 0, 0, 0, 16'h0000);
      step("beqz_nt",  16'h60FC, 16'h0040, 16'h0005, 16'h0040, 0, 0, 0, 0, 16'h0000);
      step("bnez_t",   16'h68FC, 16'h0040, 16'h0005, 16'h003C, 0, 0, 0, 0, 16'h0000);
      step("bltz_t",   16'h7004, 16'h0100, 16'h8000, 16'h0104, 0, 0, 0, 0, 16'h0000);
      step("bgez_nt",  16'h7804, 16'h0100, 16'h8000, 16'h0100, 0, 0, 0, 0, 16'h0000);
      step("jalr",     16'h3804, 16'h0050, 16'h1000, 16'h1004, 0, 0, 1, 0, 16'h0000);
      step("jr_neg",   16'h28FE, 16'h0050, 16'h1000, 16'h0FFE, 0, 0, 0, 0, 16'h0000);
      step("j_wrap",   16'h27FF, 16'hFFFE, 16'h0000, 16'hFFFD, 0, 0, 0, 0, 16'h0000);
      step("jal_neg",  16'h3400, 16'h0500, 16'h0000, 16'h0100, 0, 0, 1, 0, 16'h0000);
      step("siic",     16'h1000, 16'h0030, 16'h0000, 16'h0002, 0, 1, 0, 0, 16'h0000);
      step("hnd_nop",  16'h0800, 16'h0004, 16'h0000, 16'h0004, 0, 0, 0, 0, 16'h0030);
      step("rti",      16'h1800, 16'h0006, 16'h0000, 16'h0030, 0, 0, 0, 0, 16'h0030);
      step("siic2",    16'h1000, 16'h0040, 16'h0000, 16'h0002, 0, 1, 0, 0, 16'h0030);
      step("siic_nst", 16'h1000, 16'h0004, 16'h0000, 16'h0002, 1, 0, 0, 0, 16'h0040);
      step("halted",   16'h0000, 16'h0022, 16'h0000, 16'h0020, 1, 0, 0, 1, 16'h0040);
      for (int k = 0; k < 5; k++) begin
         r = 16'($urandom);
         q = 16'($urandom);
         step("hold", r, 16'h0022, q, 16'h0020, 1, 0, 0, 1, 16'h0040);
      end
      do_rst();
      step("post_rst", 16'h0800, 16'h0010, 16'h0000, 16'h0010, 0, 0, 0, 0, 16'h0000);
      step("rti_run",  16'h1800, 16'h0060, 16'h0000, 16'h005E, 1, 0, 0, 0, 16'h0000);
      step("rti_err",  16'h3804, 16'h0070, 16'h1000, 16'h006E, 1, 0, 0, 1, 16'h0000);
      do_rst();
      step("halt",     16'h0000, 16'h0022, 16'h0000, 16'h0020, 1, 0, 0, 0, 16'h0000);
      step("halt_hld", 16'h1000, 16'h0022, 16'h0000, 16'h0020, 1, 0, 0, 0, 16'h0000);
      do_rst();
      step("siic3",    16'h1000, 16'h0030, 16'h0000, 16'h0002, 0, 1, 0, 0, 16'h0000);
      do_rst();
      step("rst_hnd",  16'h1800, 16'h0044, 16'h0000, 16'h0042, 1, 0, 0, 0, 16'h0000);
      repeat (2) @(posedge clk);
      chk("sb_empty", 36'(sb.size()), 36'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
